// File: rtl/doppler_frame_buffer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : doppler_frame_buffer_pkg
// Description : Shared types for the Doppler frame buffer. Holds the
//               per-bank state encoding, the read FSM state encoding and a
//               constant log2 helper used to size address buses.
// Revision    : 1.0 - initial release
// ============================================================================
package doppler_frame_buffer_pkg;

  // Lifecycle of one ping-pong bank
  typedef enum logic [1:0] {
    BANK_EMPTY    = 2'd0,
    BANK_FILLING  = 2'd1,
    BANK_FULL     = 2'd2,
    BANK_DRAINING = 2'd3
  } bank_state_t;

  // Read-side sequencer
  typedef enum logic [1:0] {
    RD_IDLE   = 2'd0,
    RD_LOAD   = 2'd1,
    RD_STREAM = 2'd2
  } rd_state_t;

  // Ceiling log2, usable in constant expressions (parameter sizing)
  function automatic int log2_f(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) result = i + 1;
    end
    return result;
  endfunction

endpackage
`default_nettype wire

// File: rtl/doppler_frame_buffer_bank.sv
`default_nettype none
// ============================================================================
// Module      : frame_buf_bank
// Description : One frame of sample storage. Single write port, single read
//               port with a registered output. The output register only
//               updates on i_re, so it doubles as the hold register while the
//               downstream consumer stalls.
// Ports       : clk, rst        - clock, synchronous active-high reset
//               i_we/i_waddr/i_wdata - write strobe, address, sample
//               i_re/i_raddr    - read strobe, address
//               o_rdata         - registered read data (0 after reset)
// Revision    : 1.0 - initial release
// ============================================================================
module frame_buf_bank
  import doppler_frame_buffer_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 128,
  parameter int ADDR_W = log2_f(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic              i_re,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [DATA_W-1:0] o_rdata
);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_rdata;

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  always_ff @(posedge clk) begin
    if (rst)       r_rdata <= '0;
    else if (i_re) r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;

endmodule
`default_nettype wire

// File: rtl/doppler_frame_buffer.sv
`default_nettype none
// ============================================================================
// Module      : doppler_frame_buffer
// Description : Ping-pong frame buffer between the Hamming window stage and
//               the FFT. Collects FRAME_LEN samples per bank, then streams a
//               complete frame out with sof/eof framing and valid/ready flow
//               control. Samples arriving with no bank free are dropped and
//               counted.
// Ports       : clk, reset              - clock, synchronous active-high reset
//               in_data, in_valid       - upstream samples (no backpressure)
//               out_data, out_valid,
//               out_ready, out_sof,
//               out_eof                 - framed stream to the FFT
//               overflow, drop_count    - sticky drop flag, saturating count
// Config      : FRAME_BUF_BITREV_EN - read each frame in bit-reversed index
//               order (radix-2 DIT input); natural order when undefined.
// Revision    : 1.0 - initial release
// ============================================================================
module doppler_frame_buffer
  import doppler_frame_buffer_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int FRAME_LEN = 128
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_sof,
  output logic              out_eof,
  output logic              overflow,
  output logic [15:0]       drop_count
);

  localparam int                  c_ADDR_W = log2_f(FRAME_LEN);
  localparam logic [c_ADDR_W-1:0] c_LAST   = c_ADDR_W'(FRAME_LEN - 1);

  bank_state_t         r_bank_st [2];
  logic                r_wr_bank;
  logic [c_ADDR_W-1:0] r_wr_addr;
  rd_state_t           r_rd_state;
  logic                r_rd_bank;
  logic [c_ADDR_W-1:0] r_rd_idx;
  logic                r_out_valid;
  logic                r_out_sof;
  logic                r_out_eof;
  logic                r_overflow;
  logic [15:0]         r_drop_count;

  logic                w_wr_open;
  logic                w_wr_en;
  logic                w_drop;
  logic                w_xfer;
  logic                w_rd_last;
  logic                w_rd_fire;
  logic [c_ADDR_W-1:0] w_rd_idx_nxt;
  logic [c_ADDR_W-1:0] w_rd_addr;
  logic [DATA_W-1:0]   w_rdata [2];

  // Banks are filled strictly alternately, so the bank under the write
  // pointer is the only one that can be free; no need to search both.
  assign w_wr_open = (r_bank_st[r_wr_bank] == BANK_EMPTY) ||
                     (r_bank_st[r_wr_bank] == BANK_FILLING);
  assign w_wr_en   = in_valid & w_wr_open;
  assign w_drop    = in_valid & ~w_wr_open;

  assign w_xfer    = r_out_valid & out_ready;
  assign w_rd_last = (r_rd_idx == c_LAST);

  // The bank output register is the output stage: fetch index 0 in LOAD,
  // then fetch the next index on every non-final transfer.
  assign w_rd_fire    = (r_rd_state == RD_LOAD) | (w_xfer & ~w_rd_last);
  assign w_rd_idx_nxt = (r_rd_state == RD_LOAD) ? '0 : r_rd_idx + c_ADDR_W'(1);

`ifdef FRAME_BUF_BITREV_EN
  always_comb begin
    w_rd_addr = '0;
    for (int i = 0; i < c_ADDR_W; i++) begin
      w_rd_addr[i] = w_rd_idx_nxt[c_ADDR_W-1-i];
    end
  end
`else
  assign w_rd_addr = w_rd_idx_nxt;
`endif

  for (genvar b = 0; b < 2; b++) begin : g_bank
    frame_buf_bank #(
      .DATA_W (DATA_W),
      .DEPTH  (FRAME_LEN),
      .ADDR_W (c_ADDR_W)
    ) u_bank (
      .clk     (clk),
      .rst     (reset),
      .i_we    (w_wr_en & (r_wr_bank == 1'(b))),
      .i_waddr (r_wr_addr),
      .i_wdata (in_data),
      .i_re    (w_rd_fire & (r_rd_bank == 1'(b))),
      .i_raddr (w_rd_addr),
      .o_rdata (w_rdata[b])
    );
  end

  // Write side only touches EMPTY/FILLING banks and the read side only
  // FULL/DRAINING ones, so their bank-state updates never collide.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_bank_st[0] <= BANK_EMPTY;
      r_bank_st[1] <= BANK_EMPTY;
      r_wr_bank    <= 1'b0;
      r_wr_addr    <= '0;
      r_rd_state   <= RD_IDLE;
      r_rd_bank    <= 1'b0;
      r_rd_idx     <= '0;
      r_out_valid  <= 1'b0;
      r_out_sof    <= 1'b0;
      r_out_eof    <= 1'b0;
      r_overflow   <= 1'b0;
      r_drop_count <= '0;
    end else begin
      if (w_wr_en) begin
        r_wr_addr <= r_wr_addr + c_ADDR_W'(1);
        if (r_wr_addr == c_LAST) begin
          r_bank_st[r_wr_bank] <= BANK_FULL;
          r_wr_bank            <= ~r_wr_bank;
        end else begin
          r_bank_st[r_wr_bank] <= BANK_FILLING;
        end
      end

      if (w_drop) begin
        r_overflow <= 1'b1;
        if (r_drop_count != 16'hFFFF) r_drop_count <= r_drop_count + 16'd1;
      end

      case (r_rd_state)
        RD_IDLE: begin
          // r_rd_bank always names the oldest unread frame
          if (r_bank_st[r_rd_bank] == BANK_FULL) begin
            r_bank_st[r_rd_bank] <= BANK_DRAINING;
            r_rd_state           <= RD_LOAD;
          end
        end
        RD_LOAD: begin
          r_rd_state  <= RD_STREAM;
          r_rd_idx    <= '0;
          r_out_valid <= 1'b1;
          r_out_sof   <= 1'b1;
          r_out_eof   <= 1'b0;
        end
        RD_STREAM: begin
          if (w_xfer) begin
            if (w_rd_last) begin
              r_bank_st[r_rd_bank] <= BANK_EMPTY;
              r_rd_bank            <= ~r_rd_bank;
              r_out_valid          <= 1'b0;
              r_out_sof            <= 1'b0;
              r_out_eof            <= 1'b0;
              if (r_bank_st[~r_rd_bank] == BANK_FULL) begin
                r_bank_st[~r_rd_bank] <= BANK_DRAINING;
                r_rd_state            <= RD_LOAD;
              end else begin
                r_rd_state <= RD_IDLE;
              end
            end else begin
              r_rd_idx  <= w_rd_idx_nxt;
              r_out_sof <= 1'b0;
              r_out_eof <= (w_rd_idx_nxt == c_LAST);
            end
          end
        end
        default: r_rd_state <= RD_IDLE;
      endcase
    end
  end

  assign out_data   = w_rdata[r_rd_bank];
  assign out_valid  = r_out_valid;
  assign out_sof    = r_out_sof;
  assign out_eof    = r_out_eof;
  assign overflow   = r_overflow;
  assign drop_count = r_drop_count;

endmodule
`default_nettype wire

// File: tb/tb_doppler_frame_buffer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_doppler_frame_buffer
// Description : Self-checking bench for doppler_frame_buffer. A frame-level
//               reference model (sample queues, frame completion times,
//               occupancy count) predicts every output on every cycle;
//               directed scenarios add hand-computed literal checks, then a
//               randomized phase exercises drops, stalls and resets.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_doppler_frame_buffer;

  localparam int DATA_W = 32;
  localparam int N      = 128;
  localparam int LOGN   = 7;

  logic              clk = 1'b0;
  logic              reset;
  logic [DATA_W-1:0] in_data;
  logic              in_valid;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;
  logic              out_sof;
  logic              out_eof;
  logic              overflow;
  logic [15:0]       drop_count;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  doppler_frame_buffer #(.DATA_W(DATA_W), .FRAME_LEN(N)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_sof    (out_sof),
    .out_eof    (out_eof),
    .overflow   (overflow),
    .drop_count (drop_count)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Position in the frame of the k-th sample sent out
  function automatic int rd_order(input int k);
    int r;
`ifdef FRAME_BUF_BITREV_EN
    r = 0;
    for (int i = 0; i < LOGN; i++) if (k[i]) r = r | (1 << (LOGN - 1 - i));
`else
    r = k;
`endif
    return r;
  endfunction

  // ---------------- reference model ----------------
  logic [DATA_W-1:0] exp_q [$];   // complete frames awaiting output, in order
  logic [DATA_W-1:0] part_q [$];  // frame being collected
  int                fdone [$];   // edge at which each buffered frame completed
  int                rd_idx;      // transfers done from the head frame
  int                head_start;  // first cycle the head frame may be shown
  int                last_eof;    // edge of the most recent eof transfer
  int                m_dc;
  bit                m_ov;
  bit                model_on = 1'b0;

  function automatic int imax(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  always @(negedge clk) begin : model
    bit ev, acc, xfer;
    ev = (fdone.size() > 0) && (cyc >= head_start);
    if (model_on) begin
      check("out_valid", out_valid, ev);
      if (ev && out_valid) begin
        check("out_data", out_data, exp_q[rd_order(rd_idx)]);
        check("out_sof", out_sof, rd_idx == 0);
        check("out_eof", out_eof, rd_idx == N - 1);
      end
      check("overflow", overflow, m_ov);
      check("drop_count", drop_count, m_dc);
    end
    // advance the model across the coming edge (cyc + 1)
    if (reset) begin
      exp_q.delete(); part_q.delete(); fdone.delete();
      rd_idx = 0; head_start = 0; last_eof = -100; m_dc = 0; m_ov = 0;
      model_on = 1'b1;
    end else if (model_on) begin
      // a bank freed by this edge's eof is not yet writable
      acc  = in_valid && ((part_q.size() > 0) || (fdone.size() < 2));
      xfer = ev && out_ready;
      if (xfer) begin
        rd_idx++;
        if (rd_idx == N) begin
          repeat (N) void'(exp_q.pop_front());
          void'(fdone.pop_front());
          rd_idx   = 0;
          last_eof = cyc + 1;
          if (fdone.size() > 0) head_start = imax(fdone[0] + 2, last_eof + 1);
        end
      end
      if (acc) begin
        part_q.push_back(in_data);
        if (part_q.size() == N) begin
          foreach (part_q[i]) exp_q.push_back(part_q[i]);
          part_q.delete();
          fdone.push_back(cyc + 1);
          if (fdone.size() == 1) head_start = imax(cyc + 3, last_eof + 1);
        end
      end else if (in_valid) begin
        m_ov = 1'b1;
        if (m_dc < 65535) m_dc++;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic feed(input int n, input int base);
    for (int i = 0; i < n; i++) begin
      in_valid = 1'b1;
      in_data  = DATA_W'(base + i);
      tick();
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_valid(input int budget);
    int w;
    w = 0;
    while (!out_valid && w < budget) begin
      tick();
      w++;
    end
  endtask

  initial begin
    int e;
    int exp2;
    logic [DATA_W-1:0] held;
    int pin, pr;

    reset = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    tick(); tick();
    reset = 1'b0;
    check("reset_out_valid", out_valid, 0);
    check("reset_out_data", out_data, 0);
    check("reset_sof_eof", {out_sof, out_eof}, 0);
    check("reset_overflow", overflow, 0);
    check("reset_drop_count", drop_count, 0);

    // one frame 0..127, out_ready high: first output 2 cycles after last write
    out_ready = 1'b1;
    feed(N, 0);
    e = cyc;
    wait_valid(10);
    check("first_valid_latency", cyc - e, 2);
    check("first_sample", out_data, 0);
    check("first_sof", out_sof, 1);
`ifdef FRAME_BUF_BITREV_EN
    exp2 = 64;
`else
    exp2 = 1;
`endif
    tick();
    check("second_sample", out_data, exp2);
    repeat (140) tick();

    // two frames held back, third frame's first sample is dropped
    out_ready = 1'b0;
    feed(N, 1000);
    feed(N, 2000);
    check("no_drop_two_frames", drop_count, 0);
    feed(1, 9999);
    check("overflow_third_frame", overflow, 1);
    check("drop_count_third_frame", drop_count, 1);
    out_ready = 1'b1;
    repeat (300) tick();

    // stall 1,0,0,1 mid-frame
    feed(N, 3000);
    wait_valid(10);
    repeat (20) tick();
    held = out_data;
    out_ready = 1'b0;
    tick();
    check("stall_hold_1", out_data, held);
    tick();
    check("stall_hold_2", out_data, held);
    out_ready = 1'b1;
    repeat (140) tick();

    // reset in the middle of frame 2
    feed(N, 4000);
    feed(60, 5000);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("midreset_out_valid", out_valid, 0);
    check("midreset_out_data", out_data, 0);
    check("midreset_sof_eof", {out_sof, out_eof}, 0);
    check("midreset_overflow", overflow, 0);
    check("midreset_drop_count", drop_count, 0);
    feed(N, 6000);
    repeat (140) tick();

    // two back-to-back frames
    feed(N, 7000);
    feed(N, 7000 + N);
    repeat (300) tick();

    // randomized traffic, stalls and rare resets
    for (int blk = 0; blk < 8; blk++) begin
      pin = $urandom_range(40, 100);
      pr  = $urandom_range(20, 100);
      for (int c = 0; c < 500; c++) begin
        in_valid  = ($urandom_range(0, 99) < pin);
        in_data   = $urandom();
        out_ready = ($urandom_range(0, 99) < pr);
        reset     = ($urandom_range(0, 1999) == 0);
        tick();
      end
    end
    reset = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    repeat (400) tick();
    check("all_frames_drained", fdone.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
